// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrf_param.sv
// Latch-based register file with DEPTH entries of WIDTH bits.
// It has one flopped write stage, per-row low-phase write enables,
// bit-masked asynchronously cleared latch storage, and a combinational
// or registered read port.
module gf180mcu_fd_sc_mcu9t5v0__latrf_param #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned RD_REG = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] WM,
    input  logic [AW-1:0]    RA,
    output logic [WIDTH-1:0] RD,
    output logic             WERR
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic                        wa_ok;
    logic                        we_q;
    logic [AW-1:0]               wa_q;
    logic [WIDTH-1:0]            wd_q;
    logic [WIDTH-1:0]            wm_q;
    logic                        werr_q;
    logic [DEPTH-1:0]            row_en;
    logic [DEPTH-1:0][WIDTH-1:0] row_data;
    logic [WIDTH-1:0]            rd_comb;

    assign wa_ok = ({1'b0, WA} < DEPTH_W);

    // Write stage: capture the request on the rising edge. Out-of-range requests are dropped here.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            wm_q <= '0;
        end else begin
            we_q <= WE & wa_ok;
            wa_q <= WA;
            wd_q <= WD;
            wm_q <= WM;
        end
    end

    // Sticky error flag. It is set by any write request aimed past the last entry.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            werr_q <= 1'b0;
        end else if (WE && !wa_ok) begin
            werr_q <= 1'b1;
        end
    end

    assign WERR = werr_q;

    // Row enables: flopped decode gated by the low clock phase only, so they are glitch-free.
    always_comb begin
        row_en = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            row_en[r] = ~CLK & we_q & (wa_q == AW'(r));
        end
    end

    // Each storage bit is a separate latch, which keeps every bit to a single driver.
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic bit_q;

            // Level-sensitive storage bit. Reset clears it and dominates any open enable.
            always_latch begin
                if (!RN) begin
                    bit_q <= 1'b0;
                end else if (row_en[r] && wm_q[b]) begin
                    bit_q <= wd_q[b];
                end
            end

            assign row_data[r][b] = bit_q;
        end
    end

    // Read mux. Addresses past the last entry read as zero.
    always_comb begin
        rd_comb = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (RA == AW'(r)) begin
                rd_comb = row_data[r];
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [WIDTH-1:0] rd_q;

        // Registered read port: one cycle of latency, cleared by reset.
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_comb;
            end
        end

        assign RD = rd_q;
    end else begin : g_rd_comb
        assign RD = rd_comb;
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latrf_param.sv
// Testbench with three instances that share stimulus.
// u0 is DEPTH=4 with a combinational read, u1 is DEPTH=4 with a registered read,
// and u2 is DEPTH=3 with a combinational read. All three have AW=2.
module tb_gf180mcu_fd_sc_mcu9t5v0__latrf_param;

    logic       CLK;
    logic       RN;
    logic       WE;
    logic [1:0] WA;
    logic [7:0] WD;
    logic [7:0] WM;
    logic [1:0] RA;
    logic [7:0] rd0, rd1, rd2;
    logic       werr0, werr1, werr2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         inst;
        bit         is_err;
        logic [7:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];

    // Reference model state
    logic [7:0] m0 [4];
    logic [7:0] m1 [4];
    logic [7:0] m2 [3];
    logic       e0, e1, e2;

    gf180mcu_fd_sc_mcu9t5v0__latrf_param #(.WIDTH(8), .DEPTH(4), .RD_REG(0)) u0 (
        .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .WD(WD), .WM(WM), .RA(RA),
        .RD(rd0), .WERR(werr0));
    gf180mcu_fd_sc_mcu9t5v0__latrf_param #(.WIDTH(8), .DEPTH(4), .RD_REG(1)) u1 (
        .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .WD(WD), .WM(WM), .RA(RA),
        .RD(rd1), .WERR(werr1));
    gf180mcu_fd_sc_mcu9t5v0__latrf_param #(.WIDTH(8), .DEPTH(3), .RD_REG(0)) u2 (
        .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .WD(WD), .WM(WM), .RA(RA),
        .RD(rd2), .WERR(werr2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] observe(int inst, bit is_err);
        case (inst)
            0:       return is_err ? {7'd0, werr0} : rd0;
            1:       return is_err ? {7'd0, werr1} : rd1;
            default: return is_err ? {7'd0, werr2} : rd2;
        endcase
    endfunction

    task automatic push(int inst, bit is_err, logic [7:0] exp, string tag);
        sb_t e;
        e.inst = inst; e.is_err = is_err; e.exp = exp; e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Pop all pending expectations and compare each against the live DUT outputs.
    task automatic drain();
        sb_t e;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = observe(e.inst, e.is_err);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s inst=%0d observed=%h expected=%h", e.tag, e.inst, obs, e.exp);
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin m0[i] = '0; m1[i] = '0; end
        for (int i = 0; i < 3; i++) m2[i] = '0;
        e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
    endtask

    task automatic push_werr(string tag);
        push(0, 1'b1, {7'd0, e0}, tag);
        push(1, 1'b1, {7'd0, e1}, tag);
        push(2, 1'b1, {7'd0, e2}, tag);
    endtask

    // Drive one write request so that it is sampled at the next posedge, then update the model.
    task automatic do_write(logic [1:0] wa, logic [7:0] wd, logic [7:0] wm);
        @(negedge CLK);
        WE = 1'b1; WA = wa; WD = wd; WM = wm;
        @(posedge CLK);
        #1 WE = 1'b0;
        m0[wa] = (m0[wa] & ~wm) | (wd & wm);
        m1[wa] = (m1[wa] & ~wm) | (wd & wm);
        if (wa < 3) m2[wa] = (m2[wa] & ~wm) | (wd & wm);
        else        e2 = 1'b1;
    endtask

    // Read every address and check it one cycle later, after the registered port has captured.
    task automatic read_all(string tag);
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK);
            RA = 2'(r);
            push(0, 1'b0, m0[r], tag);
            push(1, 1'b0, m1[r], tag);
            push(2, 1'b0, (r < 3) ? m2[r] : 8'h00, tag);
            @(posedge CLK);
            #1 drain();
        end
    endtask

    initial begin
        RN = 1'b0; WE = 1'b0; WA = '0; WD = '0; WM = '0; RA = '0;
        model_clear();

        // Reset state
        #2;
        push(0, 1'b0, 8'h00, "reset_rd"); push(1, 1'b0, 8'h00, "reset_rd");
        push(2, 1'b0, 8'h00, "reset_rd"); push_werr("reset_werr");
        drain();
        #10 RN = 1'b1;
        read_all("reset_all");

        // Fill with 0xFF, then reset asynchronously in mid-cycle while CLK is high
        for (int i = 0; i < 4; i++) do_write(2'(i), 8'hFF, 8'hFF);
        read_all("fill_ff");
        @(negedge CLK);
        RA = 2'd0;
        @(posedge CLK);
        #2 RN = 1'b0;
        model_clear();
        #1;
        push(0, 1'b0, 8'h00, "async_clr"); push(1, 1'b0, 8'h00, "async_clr");
        push(2, 1'b0, 8'h00, "async_clr"); push_werr("async_clr_werr");
        drain();
        // Hold a write request through reset and release RN while CLK is low.
        WE = 1'b1; WA = 2'd0; WD = 8'hFF; WM = 8'hFF;
        @(negedge CLK);
        #1 RN = 1'b1;
        #2 push(0, 1'b0, 8'h00, "release_low_nowrite");
        push(2, 1'b0, 8'h00, "release_low_nowrite");
        drain();
        WE = 1'b0;
        read_all("post_release");

        // Basic write and read
        do_write(2'd2, 8'hA5, 8'hFF);
        read_all("basic_a5");

        // Masked writes, and an empty mask as a no-op
        do_write(2'd1, 8'h3C, 8'hFF);
        do_write(2'd1, 8'hFF, 8'h0F);
        read_all("mask_0f");
        do_write(2'd1, 8'h55, 8'h00);
        read_all("mask_00");
        push_werr("mask_00_werr");
        drain();

        // Out-of-range write on u2 (WA=3 is valid on u0/u1)
        push_werr("oor_before");
        drain();
        do_write(2'd3, 8'h77, 8'hFF);
        push_werr("oor_after");
        drain();
        do_write(2'd0, 8'h12, 8'hFF);
        push_werr("oor_sticky");
        drain();
        read_all("oor_reads");

        // Read-during-write at RA=WA=3, old value 0x11 and new value 0x22
        do_write(2'd3, 8'h11, 8'hFF);
        @(negedge CLK);
        RA = 2'd3;
        WE = 1'b1; WA = 2'd3; WD = 8'h22; WM = 8'hFF;
        @(posedge CLK);
        #1 WE = 1'b0;
        push(0, 1'b0, 8'h11, "rdw_high_old"); push(1, 1'b0, 8'h11, "rdw_reg_old");
        drain();
        @(negedge CLK);
        #1 push(0, 1'b0, 8'h22, "rdw_low_new");
        push(1, 1'b0, 8'h11, "rdw_reg_hold");
        drain();
        @(posedge CLK);
        #1 push(0, 1'b0, 8'h22, "rdw_next_new"); push(1, 1'b0, 8'h22, "rdw_reg_new");
        drain();
        m0[3] = 8'h22; m1[3] = 8'h22;

        // Reset asserted while a write to entry 0 is in flight
        @(negedge CLK);
        RA = 2'd0;
        WE = 1'b1; WA = 2'd0; WD = 8'h5A; WM = 8'hFF;
        @(posedge CLK);
        #1 WE = 1'b0;
        @(negedge CLK);
        #1 RN = 1'b0;
        model_clear();
        #1 push(0, 1'b0, 8'h00, "midwr_clr"); push(2, 1'b0, 8'h00, "midwr_clr");
        drain();
        #1 RN = 1'b1;
        #1 push(0, 1'b0, 8'h00, "midwr_no_replay"); push(2, 1'b0, 8'h00, "midwr_no_replay");
        push_werr("midwr_werr");
        drain();
        read_all("midwr_all");
        do_write(2'd0, 8'h5A, 8'hFF);
        read_all("midwr_rewrite");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog that bounds the whole run.
    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
